// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between uart_rx, the receive FIFO and its consumer.
// slave = the FIFO itself, master = the side driving writes and draining reads.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_done;
  logic [7:0]      dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [ADDR_W:0] count;
  logic            full;
  logic            overrun;
  logic [7:0]      drop_cnt;
  logic            overrun_clr;

  modport slave (
    input  rx_data, rx_done, dout_ready, overrun_clr,
    output dout, dout_valid, count, full, overrun, drop_cnt
  );

  modport master (
    output rx_data, rx_done, dout_ready, overrun_clr,
    input  dout, dout_valid, count, full, overrun, drop_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind uart_rx with drop-on-full accounting.
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN (sticky overrun flag + saturating drop counter).
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   occ;
  logic              is_full;
  logic              rd_fire;
  logic              wr_en;

  // A full queue can still take a byte when the head leaves in the same cycle.
  assign is_full = (occ == (ADDR_W+1)'(DEPTH));
  assign rd_fire = (occ != '0) && bus.dout_ready;
  assign wr_en   = bus.rx_done && (!is_full || rd_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= bus.rx_data;
        wp      <= wp + 1'b1;
      end
      if (rd_fire) rp <= rp + 1'b1;
      case ({wr_en, rd_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.dout       = mem[rp];
  assign bus.dout_valid = (occ != '0);
  assign bus.count      = occ;
  assign bus.full       = is_full;

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic       drop;
  logic       ovr;
  logic [7:0] dcnt;

  assign drop = bus.rx_done && !wr_en;

  // A drop coinciding with a clear restarts the count at one rather than zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      dcnt <= 8'h00;
    end else if (drop) begin
      ovr  <= 1'b1;
      if (bus.overrun_clr)     dcnt <= 8'h01;
      else if (dcnt != 8'hFF)  dcnt <= dcnt + 8'h01;
    end else if (bus.overrun_clr) begin
      ovr  <= 1'b0;
      dcnt <= 8'h00;
    end
  end

  assign bus.overrun  = ovr;
  assign bus.drop_cnt = dcnt;
`else
  logic unused_clr;
  assign unused_clr   = bus.overrun_clr;
  assign bus.overrun  = 1'b0;
  assign bus.drop_cnt = 8'h00;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of `uart_rx`. Captures each byte presented on `rx_data` when `rx_done` pulses and queues it in a DEPTH-entry first-word-fall-through FIFO. The consumer (CPU interface or packet logic) drains it through a valid/ready handshake. Decouples the bit-rate receiver from a bursty consumer and flags bytes lost to overflow.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥ 2
- `ADDR_W`, 4, log2(DEPTH); must match DEPTH
- `clk`  input  1  system clock; all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `rx_data`  input  8  byte from `uart_rx`; valid only in the cycle `rx_done`=1
- `rx_done`  input  1  single-cycle write strobe from `uart_rx`
- `dout`  output  8  head-of-queue byte; meaningful only when `dout_valid`=1
- `dout_valid`  output  1  queue non-empty
- `dout_ready`  input  1  consumer accepts `dout` this cycle
- `count`  output  ADDR_W+1  current occupancy, 0..DEPTH
- `full`  output  1  `count`==DEPTH
- `overrun`  output  1  sticky: at least one byte dropped
- `drop_cnt`  output  8  saturating count of dropped bytes
- `overrun_clr`  input  1  clears `overrun` and `drop_cnt`

## Operation
- Storage: DEPTH×8 register array; write pointer `wp` and read pointer `rp`, each ADDR_W bits, wrap naturally from DEPTH-1 to 0; separate occupancy counter drives `count`, `full`, `dout_valid`.
- Write: `rx_done`=1 and (`full`=0 or read fires same cycle) → `mem[wp]`←`rx_data`, `wp`+1.
- Read fires when `dout_valid`=1 and `dout_ready`=1 → `rp`+1. `dout` is always `mem[rp]` (FWFT, no read latency).
- Occupancy: +1 on write only, −1 on read only, unchanged on both or neither.
- Full + `rx_done` + read same cycle: write accepted, count stays DEPTH, no drop.
- Full + `rx_done`, no read: byte dropped, memory and pointers unchanged, drop event raised.
- Empty + `rx_done` + `dout_ready`: no read (`dout_valid`=0); write accepted, count→1.
- `dout_ready` while empty: ignored, no pointer movement, no underflow.
- Drop event: `overrun`←1; `drop_cnt`+1, saturating at 255.
- `overrun_clr`: `overrun`←0, `drop_cnt`←0. A drop event in the same cycle wins: `overrun`=1, `drop_cnt`=1.
- No FSM beyond the pointer/count datapath; `rx_done` is assumed single-cycle and is never re-sampled across cycles.

## Timing
- Reset (synchronous, one edge with `rst`=1): `wp`=`rp`=0, `count`=0, `full`=0, `dout_valid`=0, `overrun`=0, `drop_cnt`=0; `dout`=8'h00 (array cleared); any queued bytes discarded. Reset overrides every simultaneous write, read or clear.
- Write latency: byte strobed at edge N → visible on `dout` with `dout_valid`=1 in the cycle after edge N.
- Read: `dout` sampled by the consumer in the same cycle `dout_ready`=1; next entry is presented after that edge.
- Sustained throughput: one write and one read per clock.
- `count`, `full`, `overrun`, `drop_cnt` are registered and update on the edge following the causing event.

## Configuration
- `UART_RX_FIFO_OVERRUN_EN` defined: overrun detection, sticky `overrun`, and saturating `drop_cnt` implemented as above.
- Not defined: ports remain; `overrun` tied 0, `drop_cnt` tied 8'h00, `overrun_clr` ignored. Dropped-on-full behaviour is unchanged: the byte is still discarded silently.

## Test plan
- Reset, then single byte 8'hA5 strobed with `dout_ready`=0 → next cycle `dout_valid`=1, `dout`=8'hA5, `count`=1; pulse `dout_ready` → `dout_valid`=0, `count`=0.
- Write 8'h00..8'h0F (16 bytes), `dout_ready`=0 → `full`=1, `count`=16; drain → bytes read in order 8'h00..8'h0F; then 20 more writes/reads exercise pointer wrap with correct order.
- Full, strobe 8'hEE with no read (macro on) → byte dropped, `overrun`=1, `drop_cnt`=1, `count`=16, head still 8'h00; same with macro off → `overrun`=0, `drop_cnt`=0.
- Full, strobe 8'h77 with `dout_ready`=1 in same cycle → no drop, `count`=16, 8'h77 becomes the 16th entry read out.
- 300 drops while full (macro on) → `drop_cnt`=255; `overrun_clr` coincident with another drop → `overrun`=1, `drop_cnt`=1; clear alone → both 0.
- 5 bytes queued, assert `rst` for one cycle alongside `rx_done` and `dout_ready` → `count`=0, `dout_valid`=0, `full`=0, `overrun`=0 the following cycle.
